block_field: RTL and testbench

BLOCK_FIELD -- requirements
Module: block_field

---
 rtl/block_field.sv | 167 ++++++++++++++++
 tb/tb_block_field.sv | 135 +++++++++++++
 2 files changed

// File: rtl/block_field.sv
// Block field for a breakout game: a 32-bit alive bitmap and a scanner that finds
// the first block the latched ball overlaps, then clears it and reports which face was hit.
module block_field #(
  parameter int R_BALL = 8,
  parameter int N_COLS = 8,
  parameter int N_ROWS = 4,
  parameter int W_BLK  = 80,
  parameter int H_BLK  = 20,
  parameter int P_ROW  = 24,
  parameter int Y_TOP  = 48
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] x_ball,
  input  logic [9:0] y_ball,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic       hit_block,
  output logic       hit_block_u,
  output logic       hit_block_d,
  output logic       hit_block_l,
  output logic       hit_block_r,
  output logic       area,
  output logic [5:0] score,
  output logic       all_clear
);

  localparam int N_BLK = N_COLS * N_ROWS;

  typedef enum logic [1:0] {IDLE, SCAN, HIT, DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_alive;
  logic [5:0]  r_score;
  logic [3:0]  r_hit;   // {u, d, l, r}
  logic [4:0]  r_idx;
  logic [9:0]  r_x_lat, r_y_lat;

  logic        w_same, w_ovl;
  logic [10:0] w_left, w_right, w_top, w_bot;
  logic [10:0] w_xp, w_xm, w_yp, w_ym;
  logic [10:0] w_pu, w_pd, w_pl, w_pr;
  logic [3:0]  w_dir;
  logic [N_COLS-1:0] w_in_col;
  logic [N_ROWS-1:0] w_in_row;

  assign w_same = (x_ball == r_x_lat) && (y_ball == r_y_lat);

  // Edges of the block currently addressed by the scan index
  always_comb begin
    w_left  = 11'(W_BLK * (int'(r_idx) % N_COLS));
    w_right = w_left + 11'(W_BLK - 1);
    w_top   = 11'(Y_TOP + P_ROW * (int'(r_idx) / N_COLS));
    w_bot   = w_top + 11'(H_BLK - 1);
  end

  // Ball extents; the low side clamps at 0 instead of wrapping
  assign w_xp = {1'b0, r_x_lat} + 11'(R_BALL);
  assign w_yp = {1'b0, r_y_lat} + 11'(R_BALL);
  assign w_xm = (r_x_lat >= 10'(R_BALL)) ? {1'b0, r_x_lat - 10'(R_BALL)} : 11'd0;
  assign w_ym = (r_y_lat >= 10'(R_BALL)) ? {1'b0, r_y_lat - 10'(R_BALL)} : 11'd0;

  assign w_ovl = (int'(r_idx) < N_BLK) && r_alive[r_idx] &&
                 (w_xp >= w_left) && (w_xm <= w_right) &&
                 (w_yp >= w_top)  && (w_ym <= w_bot);

  // Penetration depths are only meaningful while the block overlaps (HIT state)
  assign w_pu = w_yp - w_top + 11'd1;
  assign w_pd = w_bot - w_ym + 11'd1;
  assign w_pl = w_xp - w_left + 11'd1;
  assign w_pr = w_right - w_xm + 11'd1;

  always_comb begin
    w_dir = 4'b0001;
    if (w_pu <= w_pd && w_pu <= w_pl && w_pu <= w_pr) w_dir = 4'b1000;
    else if (w_pd <= w_pl && w_pd <= w_pr)             w_dir = 4'b0100;
    else if (w_pl <= w_pr)                             w_dir = 4'b0010;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = SCAN;
      SCAN: begin
        if (!start)              w_next = IDLE;
        else if (w_ovl)          w_next = HIT;
        else if (r_idx == 5'd31) w_next = DONE;
      end
      HIT:  w_next = start ? DONE : IDLE;
      DONE: begin
        if (!start)       w_next = IDLE;
        else if (!w_same) w_next = SCAN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alive <= '1;
      r_score <= '0;
      r_hit   <= '0;
      r_idx   <= '0;
      r_x_lat <= '0;
      r_y_lat <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hit <= '0;
          if (!start) begin
            r_alive <= '1;
            r_score <= '0;
          end else begin
            r_x_lat <= x_ball;
            r_y_lat <= y_ball;
            r_idx   <= '0;
          end
        end
        SCAN: if (start && !w_ovl && r_idx != 5'd31) r_idx <= r_idx + 5'd1;
        HIT: if (start) begin
          r_alive[r_idx] <= 1'b0;
          if (r_score != 6'd32) r_score <= r_score + 6'd1;
          r_hit <= w_dir;
        end
        DONE: if (start && !w_same) begin
          r_x_lat <= x_ball;
          r_y_lat <= y_ball;
          r_hit   <= '0;
          r_idx   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Flags are qualified by the live position so they vanish as soon as the ball moves
  assign hit_block_u = r_hit[3] & w_same;
  assign hit_block_d = r_hit[2] & w_same;
  assign hit_block_l = r_hit[1] & w_same;
  assign hit_block_r = r_hit[0] & w_same;
  assign hit_block   = hit_block_u | hit_block_d | hit_block_l | hit_block_r;

  assign score     = r_score;
  assign all_clear = (r_alive == 32'd0);

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    assign w_in_col[c] = ({1'b0, next_x} >= 11'(W_BLK * c)) &&
                         ({1'b0, next_x} <= 11'(W_BLK * c + W_BLK - 1));
  end
  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    assign w_in_row[r] = ({1'b0, next_y} >= 11'(Y_TOP + P_ROW * r)) &&
                         ({1'b0, next_y} <= 11'(Y_TOP + P_ROW * r + H_BLK - 1));
  end

  always_comb begin
    area = 1'b0;
    for (int k = 0; k < N_BLK; k++)
      if (w_in_col[k % N_COLS] && w_in_row[k / N_COLS] && r_alive[k]) area = 1'b1;
  end

endmodule

// File: tb/tb_block_field.sv
// Directed bench for block_field: scan miss, face detection, rescan, reset abort, full clear.
module tb_block_field;
  logic       clock, reset, start;
  logic [9:0] x_ball, y_ball, next_x, next_y;
  logic       hit_block, hit_block_u, hit_block_d, hit_block_l, hit_block_r;
  logic       area, all_clear;
  logic [5:0] score;

  int n_chk = 0;
  int n_pass = 0;

  block_field dut (
    .clock(clock), .reset(reset), .start(start),
    .x_ball(x_ball), .y_ball(y_ball), .next_x(next_x), .next_y(next_y),
    .hit_block(hit_block), .hit_block_u(hit_block_u), .hit_block_d(hit_block_d),
    .hit_block_l(hit_block_l), .hit_block_r(hit_block_r),
    .area(area), .score(score), .all_clear(all_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic pix(input int px, input int py);
    next_x = 10'(px);
    next_y = 10'(py);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Bounded wait for hit_block; a timeout shows up as the caller's failed check
  task automatic wait_hit(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (hit_block) break;
    end
  endtask

  initial begin
    int nh;
    reset = 1'b0; start = 1'b0;
    x_ball = '0; y_ball = '0; next_x = '0; next_y = '0;
    cyc(2);
    pix(5, 50);
    chk("rst_hit", hit_block, 0);
    chk("rst_score", score, 0);
    chk("rst_clear", all_clear, 0);
    chk("rst_area", area, 1);

    reset = 1'b1;
    cyc(1);
    start = 1'b1; x_ball = 10'd320; y_ball = 10'd240;
    cyc(36);
    chk("miss_hit", hit_block, 0);
    chk("miss_score", score, 0);
    pix(5, 50); chk("area_blk0", area, 1);
    pix(5, 70); chk("area_gap", area, 0);

    // Ball (40,146) grazes block 24 from below
    x_ball = 10'd40; y_ball = 10'd146;
    wait_hit(34);
    chk("b24_hit", hit_block, 1);
    chk("b24_dir", {hit_block_u, hit_block_d, hit_block_l, hit_block_r}, 4'b0100);
    chk("b24_score", score, 1);
    pix(40, 130); chk("b24_area", area, 0);

    x_ball = 10'd40; y_ball = 10'd144;
    #1 chk("move_drop", hit_block, 0);
    cyc(36);
    chk("rescan_hit", hit_block, 0);
    chk("rescan_score", score, 1);

    // Refill, then a ball straddling blocks 0 and 1
    start = 1'b0;
    cyc(3);
    chk("refill_score", score, 0);
    start = 1'b1; x_ball = 10'd85; y_ball = 10'd60;
    wait_hit(40);
    chk("b0_dir", {hit_block_u, hit_block_d, hit_block_l, hit_block_r}, 4'b0001);
    chk("b0_score", score, 1);
    pix(5, 50);   chk("b0_area", area, 0);
    pix(100, 50); chk("b1_area", area, 1);

    // Reset in the middle of a scan
    x_ball = 10'd300; y_ball = 10'd300;
    cyc(6);
    reset = 1'b0;
    pix(5, 50);
    chk("mid_rst_area", area, 1);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_hit", hit_block, 0);
    chk("mid_rst_clear", all_clear, 0);
    cyc(1);
    reset = 1'b1;
    cyc(36);
    chk("post_rst_hit", hit_block, 0);
    chk("post_rst_score", score, 0);

    // Visit every block centre once
    nh = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        x_ball = 10'(80 * c + 40);
        y_ball = 10'(58 + 24 * r);
        wait_hit(40);
        if (hit_block) nh++;
      end
    chk("clr_hits", nh, 32);
    chk("clr_score", score, 32);
    chk("clr_all", all_clear, 1);
    pix(5, 50); chk("clr_area", area, 0);

    x_ball = 10'd200; y_ball = 10'd60;
    cyc(36);
    chk("empty_hit", hit_block, 0);
    chk("empty_score", score, 32);

    start = 1'b0;
    cyc(3);
    chk("end_score", score, 0);
    chk("end_clear", all_clear, 0);
    pix(5, 50); chk("end_area", area, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
